// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one always-ready SRAM port among NumPorts requesters.
// Grant is combinational in the request cycle; rvalid_o returns to the owner exactly Latency cycles later.
module mem_port_arbiter #(
  parameter int NumPorts  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int Latency   = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumPorts-1:0]                   req_i,
  output logic [NumPorts-1:0]                   gnt_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumPorts-1:0]                   we_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0]  strb_i,
  output logic [NumPorts-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  mem_req_o,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic                                  mem_we_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  output logic [DataWidth/8-1:0]                mem_strb_o,
  input  logic [DataWidth-1:0]                  mem_rdata_i
);

  localparam int IdxW = $clog2(NumPorts);

  typedef logic [IdxW-1:0] idx_t;
  typedef struct packed {
    logic vld;
    idx_t idx;
  } rsp_t;

  idx_t                ptr_q;
  idx_t                ptr_nxt;
  idx_t                gnt_idx;
  idx_t                cand_idx;
  logic                gnt_vld;
  int                  cand;
  rsp_t                rsp_in;
  rsp_t [Latency-1:0]  pipe_q;

  // Scan requesters starting at the priority pointer, wrapping modulo NumPorts.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NumPorts; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NumPorts) cand = cand - NumPorts;
      cand_idx = idx_t'(cand);
      if (!rst_i && !gnt_vld && req_i[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_vld) gnt_o[gnt_idx] = 1'b1;
  end

  assign ptr_nxt     = (gnt_idx == idx_t'(NumPorts - 1)) ? '0 : gnt_idx + idx_t'(1);
  assign mem_req_o   = (|req_i) && !rst_i;
  assign mem_addr_o  = addr_i[gnt_idx];
  assign mem_wdata_o = wdata_i[gnt_idx];
  assign mem_we_o    = gnt_vld && we_i[gnt_idx];
  assign mem_strb_o  = gnt_vld ? strb_i[gnt_idx] : '0;
  assign rdata_o     = mem_rdata_i;
  assign rsp_in      = '{vld: gnt_vld, idx: gnt_idx};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= ptr_nxt;
    end
  end

  // Response tracker: one slot per cycle of memory latency, shifted unconditionally.
  generate
    if (Latency == 1) begin : g_pipe1
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= rsp_in;
      end
    end else begin : g_pipen
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= {pipe_q[Latency-2:0], rsp_in};
      end
    end
  endgenerate

  always_comb begin
    rvalid_o = '0;
    if (pipe_q[Latency-1].vld) rvalid_o[pipe_q[Latency-1].idx] = 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_port_arbiter: a round-robin reference picks the expected grant,
// and each grant queues the expected response slot LAT cycles ahead.
module tb_mem_port_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req;
  logic [N-1:0]          gnt;
  logic [N-1:0][AW-1:0]  addr;
  logic [N-1:0]          we;
  logic [N-1:0][DW-1:0]  wdata;
  logic [N-1:0][SW-1:0]  strb;
  logic [N-1:0]          rvalid;
  logic [DW-1:0]         rdata;
  logic                  mem_req;
  logic [AW-1:0]         mem_addr;
  logic                  mem_we;
  logic [DW-1:0]         mem_wdata;
  logic [SW-1:0]         mem_strb;
  logic [DW-1:0]         mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW), .Latency(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    int due;
    int port;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   ptr_m;
  int   n_chk;
  int   n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_payload();
    for (int k = 0; k < N; k++) begin
      addr[k]  = $urandom;
      wdata[k] = $urandom;
      strb[k]  = SW'($urandom);
    end
  endtask

  task automatic check_resp();
    logic [N-1:0] exp_rv;
    exp_rv = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv = N'(1) << exp_q[0].port;
      void'(exp_q.pop_front());
    end
    check_eq("rvalid", rvalid, exp_rv);
    if (exp_rv != '0) check_eq("rdata", rdata, mem_rdata);
  endtask

  // One clock cycle: drive requests, check grant/steering and responses at negedge.
  task automatic step(input logic [N-1:0] r);
    int           g;
    logic [N-1:0] exp_g;
    req       = r;
    mem_rdata = $urandom;
    @(negedge clk);
    g     = rr_pick(r, ptr_m);
    exp_g = (g < 0) ? '0 : (N'(1) << g);
    check_eq("gnt", gnt, exp_g);
    check_eq("mem_req", mem_req, |r);
    if (g >= 0) begin
      check_eq("mem_addr", mem_addr, addr[g]);
      check_eq("mem_we", mem_we, we[g]);
      check_eq("mem_wdata", mem_wdata, wdata[g]);
      check_eq("mem_strb", mem_strb, strb[g]);
      exp_q.push_back('{due: cyc + LAT, port: g});
      ptr_m = (g + 1) % N;
    end else begin
      check_eq("idle_we", mem_we, 1'b0);
      check_eq("idle_strb", mem_strb, '0);
    end
    check_resp();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '1;
    we  = '1;
    for (int k = 0; k < N; k++) strb[k] = '1;
    @(negedge clk);
    check_eq("rst_gnt", gnt, '0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_strb", mem_strb, '0);
    check_eq("rst_rvalid", rvalid, '0);
    exp_q.delete();
    ptr_m = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    req = '0;
    we  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; strb = '0; mem_rdata = '0;
    cyc = 0; ptr_m = 0; n_chk = 0; n_pass = 0;
    do_reset();

    // Single read at 0x40 from port 0.
    rand_payload();
    addr[0] = 32'h40;
    we      = '0;
    step(4'b0001);
    repeat (LAT) step('0);

    // Two-port contention from reset: 01,10,01,10.
    do_reset();
    repeat (4) begin
      rand_payload();
      step(4'b0011);
    end
    repeat (LAT) step('0);

    // Port 1 full-word write.
    rand_payload();
    we       = 4'b0010;
    addr[1]  = 32'h10;
    wdata[1] = 32'hDEADBEEF;
    strb[1]  = 4'hF;
    step(4'b0010);
    we = '0;
    repeat (LAT) step('0);

    // All ports back-to-back for 8 cycles.
    do_reset();
    repeat (8) begin
      rand_payload();
      we = N'($urandom);
      step('1);
    end
    we = '0;
    repeat (LAT) step('0);

    // Pointer holds across idle cycles.
    do_reset();
    rand_payload();
    step(4'b0100);
    repeat (5) step('0);
    step('1);
    repeat (LAT) step('0);

    // Reset while a response is in flight.
    do_reset();
    step(4'b0001);
    req = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_rvalid", rvalid, '0);
    check_eq("midrst_gnt", gnt, '0);
    exp_q.delete();
    ptr_m = 0;
    @(posedge clk); cyc++; #1;
    @(posedge clk); cyc++; #1;
    rst = 1'b0;
    repeat (LAT + 1) step('0);
    step(4'b0011);
    repeat (LAT) step('0);

    // Random traffic.
    repeat (300) begin
      rand_payload();
      we = N'($urandom);
      step(N'($urandom));
    end
    we = '0;
    repeat (LAT + 1) step('0);

    check_eq("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of memory requesters (legal range 2..8).
REQ-002 SHALL have parameter AddrWidth, default 32, byte-address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter Latency, default 1, fixed memory read latency in cycles (legal range 1..4).
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port req_i, input, [NumPorts], per-requester request valid.
REQ-008 SHALL have port gnt_o, output, [NumPorts], per-requester grant.
REQ-009 SHALL have port addr_i, input, [NumPorts][AddrWidth], request address.
REQ-010 SHALL have port we_i, input, [NumPorts], write enable.
REQ-011 SHALL have port wdata_i, input, [NumPorts][DataWidth], write data.
REQ-012 SHALL have port strb_i, input, [NumPorts][DataWidth/8], byte strobes.
REQ-013 SHALL have port rvalid_o, output, [NumPorts], response valid to the owning requester.
REQ-014 SHALL have port rdata_o, output, [DataWidth], read data broadcast to all requesters.
REQ-015 SHALL have ports mem_req_o (1), mem_addr_o (AddrWidth), mem_we_o (1), mem_wdata_o (DataWidth), mem_strb_o (DataWidth/8), outputs: the single SRAM port.
REQ-016 SHALL have port mem_rdata_i, input, DataWidth, SRAM read data valid Latency cycles after the accepted request.

Function
REQ-017 SHALL grant at most one requester per cycle, combinationally in the request cycle; the SRAM port is always ready (no memory-side stall).
REQ-018 SHALL arbitrate round-robin: a priority pointer P selects the first asserted req_i at index P, P+1, ... modulo NumPorts.
REQ-019 SHALL update P on every grant to (granted index + 1) modulo NumPorts; P SHALL hold when no request is present.
REQ-020 SHALL drive mem_req_o = |req_i and steer addr/we/wdata/strb of the granted port to the mem_* outputs; with no grant, mem_we_o and mem_strb_o SHALL be 0.
REQ-021 SHALL keep a Latency-deep shift pipeline of {valid, port index}, loaded with {1, granted index} on each grant and {0, x} otherwise, advancing every cycle.
REQ-022 SHALL assert rvalid_o[k] for exactly one cycle, exactly Latency cycles after the grant to port k, for reads and writes alike.
REQ-023 SHALL drive rdata_o = mem_rdata_i unmodified; its content is meaningful only with a read response.
REQ-024 SHALL sustain one grant per cycle with back-to-back responses and no bubbles; a new grant and a response retirement in the same cycle SHALL both take effect.
REQ-025 SHALL guarantee that a continuously asserted req_i[k] is granted within NumPorts cycles.
REQ-026 SHALL NOT require requesters to hold addr/data after a grant; a request deasserted without a grant is dropped with no side effect.

Reset
REQ-027 SHALL on rst_i, asynchronously, set P = 0, clear all pipeline valid bits, and drive rvalid_o = 0.
REQ-028 SHALL discard all in-flight responses when reset is asserted mid-operation; no rvalid_o SHALL follow reset release for pre-reset grants.
REQ-029 SHALL, while rst_i is high, drive gnt_o = 0, mem_req_o = 0, mem_we_o = 0 and mem_strb_o = 0.

Verification
REQ-030 Single port: NumPorts=2, Latency=1, req_i=01, read at 0x40 -> gnt_o=01, mem_addr_o=0x40, mem_we_o=0; the next cycle rvalid_o=01, rdata_o=mem_rdata_i.
REQ-031 Contention: req_i=11 held 4 cycles from reset -> gnt_o sequence 01,10,01,10; rvalid_o matches it delayed by Latency.
REQ-032 Write: port 1 write 0xDEADBEEF, strb 0xF, to 0x10 -> mem_we_o=1, mem_wdata_o=0xDEADBEEF, mem_strb_o=0xF; rvalid_o=10 after Latency.
REQ-033 Latency=3, NumPorts=4, all ports requesting for 8 cycles -> 8 consecutive single-hot rvalid_o pulses in order 0,1,2,3,0,1,2,3, starting 3 cycles after the first grant.
REQ-034 Reset mid-flight: Latency=2, grant port 0, assert rst_i the next cycle -> rvalid_o stays 0 and P=0 after release.
REQ-035 Idle hold: grant to port 2 of 4, then 5 idle cycles, then req_i=1111 -> port 3 is granted first.
